mem_bus_master: RTL and testbench

Avalon memory-mapped bus master that sits directly downstream of the CPU load/store stage and performs all instruction-fetch and data transfers on its behalf. It accepts one request at a time over a valid/ready handshake and drives an Avalon transfer with aligned address and byte enables, holding every bus signal stable through `waitrequest` stalls. It returns one response per request: sign- or zero-extended load data, or an error flag for misaligned, illegal or timed-out accesses.

---
 rtl/mem_bus_master.sv | 183 ++++++++++++++++++
 tb/tb_mem_bus_master.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - Avalon-MM bus master for CPU load/store and fetch requests
module mem_bus_master #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_writedata,
  output logic        rsp_valid,
  output logic [31:0] rsp_readdata,
  output logic        rsp_error,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [15:0] WAIT_LIM16 = 16'(WAIT_LIMIT);

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] address_q, address_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] writedata_q, writedata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;

  logic        req_bad;
  logic [3:0]  req_be;
  logic [31:0] req_wd;
  logic [31:0] rd_shift;
  logic [31:0] load_ext;

  // Decode the incoming request: alignment legality, lane enables and replicated store data
  always_comb begin
    req_bad = 1'b0;
    req_be  = 4'b0000;
    req_wd  = req_writedata;
    case (req_size)
      2'b00: begin
        req_be = 4'b0001 << req_address[1:0];
        req_wd = {4{req_writedata[7:0]}};
      end
      2'b01: begin
        req_bad = req_address[0];
        req_be  = req_address[1] ? 4'b1100 : 4'b0011;
        req_wd  = {2{req_writedata[15:0]}};
      end
      2'b10: begin
        req_bad = (req_address[1:0] != 2'b00);
        req_be  = 4'b1111;
      end
      default: req_bad = 1'b1;
    endcase
  end

  // Pick the addressed lane(s) out of readdata and extend to 32 bits
  always_comb begin
    rd_shift = readdata >> {lane_q, 3'b000};
    load_ext = readdata;
    case (size_q)
      2'b00: load_ext = {{24{signed_q & rd_shift[7]}}, rd_shift[7:0]};
      2'b01: begin
        if (lane_q[1]) begin
          load_ext = {{16{signed_q & readdata[31]}}, readdata[31:16]};
        end else begin
          load_ext = {{16{signed_q & readdata[15]}}, readdata[15:0]};
        end
      end
      default: load_ext = readdata;
    endcase
  end

  // Next-state logic: capture in IDLE, run the bus transfer with timeout, pulse the response
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    signed_d    = signed_q;
    lane_d      = lane_q;
    address_d   = address_q;
    be_d        = be_q;
    writedata_d = writedata_q;
    rdata_d     = rdata_q;
    error_d     = error_q;
    wait_cnt_d  = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          lane_d   = req_address[1:0];
          rdata_d  = 32'd0;
          if (req_bad) begin
            // Illegal access never touches the bus; address keeps its last value
            error_d = 1'b1;
            state_d = RESP;
          end else begin
            error_d     = 1'b0;
            address_d   = {req_address[31:2], 2'b00};
            be_d        = req_be;
            writedata_d = req_wd;
            wait_cnt_d  = 16'd0;
            state_d     = BUS;
          end
        end
      end
      BUS: begin
        if (!waitrequest) begin
          rdata_d = write_q ? 32'd0 : load_ext;
          error_d = 1'b0;
          state_d = RESP;
        end else if ((WAIT_LIMIT != 0) && (wait_cnt_q + 16'd1 == WAIT_LIM16)) begin
          rdata_d = 32'd0;
          error_d = 1'b1;
          state_d = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured-request registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      lane_q      <= 2'b00;
      address_q   <= 32'd0;
      be_q        <= 4'b0000;
      writedata_q <= 32'd0;
      rdata_q     <= 32'd0;
      error_q     <= 1'b0;
      wait_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      lane_q      <= lane_d;
      address_q   <= address_d;
      be_q        <= be_d;
      writedata_q <= writedata_d;
      rdata_q     <= rdata_d;
      error_q     <= error_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // Outputs are gated by state so an async reset drops strobes immediately
  always_comb begin
    req_ready    = (state_q == IDLE) && !reset;
    read         = (state_q == BUS) && !write_q;
    write        = (state_q == BUS) && write_q;
    byteenable   = (state_q == BUS) ? be_q : 4'b0000;
    address      = address_q;
    writedata    = writedata_q;
    rsp_valid    = (state_q == RESP);
    rsp_readdata = (state_q == RESP) ? rdata_q : 32'd0;
    rsp_error    = (state_q == RESP) && error_q;
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - scoreboard testbench for mem_bus_master
module tb_mem_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_address;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_writedata;
  logic        rsp_valid;
  logic [31:0] rsp_readdata;
  logic        rsp_error;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        waitrequest = 1'b0;

  mem_bus_master #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_size(req_size), .req_signed(req_signed),
    .req_writedata(req_writedata),
    .rsp_valid(rsp_valid), .rsp_readdata(rsp_readdata), .rsp_error(rsp_error),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  rsp_t        exp_rsp;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_addr = 32'd0;
  logic [31:0] exp_wd = 32'd0;
  logic [3:0]  exp_be = 4'd0;
  logic        exp_wr = 1'b0;
  int          wait_n = 0;
  int          cur_strobe = 0;
  int          strobe_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave model and bus checker: stall for wait_n cycles of each strobe
  always @(negedge clk) begin
    if (read || write) begin
      cur_strobe++;
      strobe_total++;
      check("rw_exclusive", {31'd0, read & write}, 32'd0);
      check("strobe_dir", {31'd0, write}, {31'd0, exp_wr});
      check("bus_address", address, exp_addr);
      check("bus_byteenable", {28'd0, byteenable}, {28'd0, exp_be});
      if (exp_wr) check("bus_writedata", writedata, exp_wd);
      waitrequest = (cur_strobe <= wait_n);
    end else begin
      cur_strobe  = 0;
      waitrequest = 1'b0;
    end
  end

  // Response monitor: pop and compare whenever a response is presented
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got data %h err %b expected no response", rsp_readdata, rsp_error);
      end else begin
        exp_rsp = exp_q.pop_front();
        check("rsp_readdata", rsp_readdata, exp_rsp.data);
        check("rsp_error", {31'd0, rsp_error}, {31'd0, exp_rsp.err});
      end
    end
  end

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                        input logic sgn, input logic [31:0] wd, input logic [31:0] rd,
                        input int wn, input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wd, input int e_strobes,
                        input logic [31:0] e_data, input logic e_err);
    int lat;
    int st0;
    int guard;
    exp_addr = e_addr;
    exp_be   = e_be;
    exp_wd   = e_wd;
    exp_wr   = wr;
    wait_n   = wn;
    readdata = rd;
    exp_q.push_back('{data: e_data, err: e_err});
    guard = 0;
    while (!req_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    st0           = strobe_total;
    req_valid     = 1'b1;
    req_write     = wr;
    req_address   = addr;
    req_size      = sz;
    req_signed    = sgn;
    req_writedata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("rsp_latency", lat, e_strobes + 1);
    @(posedge clk); #1;
    check("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
    check("strobe_cycles", strobe_total - st0, e_strobes);
    check("idle_byteenable", {28'd0, byteenable}, 32'd0);
    check("idle_strobes", {30'd0, read, write}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    reset         = 1'b1;
    req_valid     = 1'b0;
    req_write     = 1'b0;
    req_address   = 32'd0;
    req_size      = 2'b00;
    req_signed    = 1'b0;
    req_writedata = 32'd0;
    readdata      = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_strobes", {30'd0, read, write}, 32'd0);
    check("rst_rsp", {30'd0, rsp_valid, rsp_error}, 32'd0);
    check("rst_address", address, 32'd0);
    check("rst_writedata", writedata, 32'd0);
    check("rst_byteenable", {28'd0, byteenable}, 32'd0);
    check("rst_rsp_readdata", rsp_readdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_init", {31'd0, req_ready}, 32'd1);

    // wr addr size sgn wd rd wait | exp addr, be, wd, strobes, data, err
    do_req(0, 32'h100, 2'b10, 0, 32'h0, 32'hDEADBEEF, 0, 32'h100, 4'b1111, 32'h0, 1, 32'hDEADBEEF, 0);
    do_req(0, 32'h103, 2'b00, 1, 32'h0, 32'h80FF1234, 0, 32'h100, 4'b1000, 32'h0, 1, 32'hFFFFFF80, 0);
    do_req(0, 32'h103, 2'b00, 0, 32'h0, 32'h80FF1234, 0, 32'h100, 4'b1000, 32'h0, 1, 32'h00000080, 0);
    do_req(1, 32'h206, 2'b01, 0, 32'h0000ABCD, 32'h0, 3, 32'h204, 4'b1100, 32'hABCDABCD, 4, 32'h0, 0);
    do_req(0, 32'h102, 2'b10, 0, 32'h0, 32'h12345678, 0, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 1);
    do_req(0, 32'h100, 2'b11, 0, 32'h0, 32'h12345678, 0, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 1);
    do_req(1, 32'h101, 2'b01, 0, 32'h1234, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 1);
    do_req(0, 32'h002, 2'b01, 1, 32'h0, 32'h80017FFF, 1, 32'h000, 4'b1100, 32'h0, 2, 32'hFFFF8001, 0);
    do_req(0, 32'h000, 2'b01, 1, 32'h0, 32'h80017FFF, 0, 32'h000, 4'b0011, 32'h0, 1, 32'h00007FFF, 0);
    do_req(1, 32'h001, 2'b00, 0, 32'hFFFFFF5A, 32'h0, 0, 32'h000, 4'b0010, 32'h5A5A5A5A, 1, 32'h0, 0);
    do_req(1, 32'h010, 2'b10, 1, 32'h12345678, 32'hFFFFFFFF, 1, 32'h010, 4'b1111, 32'h12345678, 2, 32'h0, 0);
    do_req(0, 32'h300, 2'b10, 0, 32'h0, 32'h11111111, 100, 32'h300, 4'b1111, 32'h0, 4, 32'h0, 1);

    // Reset during the second wait cycle of a stalled load: no response may follow
    exp_addr  = 32'h400;
    exp_be    = 4'b1111;
    exp_wr    = 1'b0;
    wait_n    = 100;
    readdata  = 32'h0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_address = 32'h400;
    req_size  = 2'b10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    g = 0;
    while (cur_strobe < 2 && g < 20) begin
      @(negedge clk); #1;
      g++;
    end
    check("mid_wait_position", cur_strobe, 32'd2);
    reset = 1'b1;
    #1;
    check("reset_drops_read", {31'd0, read}, 32'd0);
    check("reset_ready_low", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_after_release", {31'd0, req_ready}, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("no_pending_rsp", exp_q.size(), 32'd0);

    do_req(0, 32'h504, 2'b10, 0, 32'h0, 32'hCAFEF00D, 2, 32'h504, 4'b1111, 32'h0, 3, 32'hCAFEF00D, 0);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
